pixel_array_controller: RTL and testbench
=========================================

# pixel_array_controller

Sequencer sitting directly upstream of the pixel array. It drives the array's ERASE, EXPOSE, RAMP, COUNTER and one-hot READ inputs through one full frame: erase, expose, ramp-convert, then row-by-row readout. During readout it gives the downstream readout stage a valid/ready handshake per row. VBN1 is a static bias and is not driven here.

## Interface

Parameters:
- PIXEL_ARRAY_HEIGHT, 2: number of rows; sets READ width. Must be ≥1.
- ERASE_CYCLES, 5: cycles ERASE is held high. Range 1..65535.
- EXPOSE_CYCLES, 255: cycles EXPOSE is held high. Range 1..65535.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- START  in  1  frame request; sampled only in IDLE.
- ERASE  out  1  pixel erase strobe.
- EXPOSE  out  1  pixel expose strobe.
- RAMP  out  1  high while the comparator ramp runs.
- COUNTER  out  8  conversion code broadcast to pixel memories.
- READ  out  PIXEL_ARRAY_HEIGHT  one-hot row select; all zero outside readout.
- ROW_VALID  out  1  the selected row's DATA_OUT is stable.
- ROW_INDEX  out  $clog2(PIXEL_ARRAY_HEIGHT) (minimum 1)  index of the row currently selected.
- ROW_READY  in  1  downstream accepts the row.
- BUSY  out  1  high in every state except IDLE.
- FRAME_DONE  out  1  one-cycle pulse after the last row is accepted.

## Operation

States and transitions:
- IDLE: all outputs 0. If START=1, go to ERASE_S.
- ERASE_S: ERASE=1 for exactly ERASE_CYCLES cycles, then go to EXPOSE_S.
- EXPOSE_S: EXPOSE=1 for exactly EXPOSE_CYCLES cycles, then go to CONVERT.
- CONVERT: RAMP=1. COUNTER shows 0 in the first CONVERT cycle and increments by 1 each cycle, for 256 cycles total. After the cycle where COUNTER=255, go to READ_SETUP with row=0. COUNTER never wraps; it is 0 in every non-CONVERT state.
- READ_SETUP: READ[row]=1, ROW_VALID=0, for exactly 1 cycle (array settle). Then go to READ_VALID.
- READ_VALID: READ[row]=1 and ROW_VALID=1, held while ROW_READY=0. On ROW_VALID && ROW_READY:
  - if row=PIXEL_ARRAY_HEIGHT-1, go to IDLE and assert FRAME_DONE in the following cycle;
  - otherwise increment row and go to READ_SETUP.
- ROW_INDEX equals row in READ_SETUP and READ_VALID, and is 0 elsewhere.
- At most one of ERASE, EXPOSE, RAMP or any READ bit is high in any cycle.

Boundary behaviour:
- START outside IDLE is ignored, not queued.
- START held high continuously starts the next frame on the first IDLE cycle, i.e. the same cycle FRAME_DONE is high.
- ROW_READY outside READ_VALID is ignored.
- PIXEL_ARRAY_HEIGHT=1: a single READ_SETUP/READ_VALID pair, then IDLE.
- reset mid-frame: on the next edge the state is IDLE, all outputs are 0 and any pending FRAME_DONE is cancelled.

## Timing

- All outputs are registered.
- Reset values: ERASE, EXPOSE, RAMP, ROW_VALID, BUSY, FRAME_DONE = 0; COUNTER = 0; READ = 0; ROW_INDEX = 0.
- START sampled high at edge k gives ERASE=1 and BUSY=1 from cycle k+1.
- Phase lengths are exact: ERASE_CYCLES, then EXPOSE_CYCLES, then 256, with no gap cycles between phases.
- Per row: 1 setup cycle, then at least 1 valid cycle.
- Minimum frame length, from the first ERASE cycle to the FRAME_DONE cycle inclusive: ERASE_CYCLES + EXPOSE_CYCLES + 256 + 2·PIXEL_ARRAY_HEIGHT + 1.
- Handshake: ROW_VALID never drops without ROW_READY. READ and ROW_INDEX stay stable while ROW_VALID=1.

## Structure

- Shared package pixel_ctrl_pkg:
  - state enum: IDLE, ERASE_S, EXPOSE_S, CONVERT, READ_SETUP, READ_VALID;
  - COUNTER_WIDTH=8;
  - PHASE_TIMER_WIDTH=16.
- Sub-module phase_timer: a loadable 16-bit down-counter with load, enable and a zero flag. One instance is shared by ERASE_S and EXPOSE_S.
- The conversion COUNTER and the row index are local registers in the top module.

## Test plan

- Reset, then idle: with START=0 for 20 cycles, all outputs stay 0 and BUSY=0.
- Full frame with defaults (H=2, E=5, X=255) and ROW_READY tied high:
  - ERASE is high for 5 cycles, then EXPOSE for 255, then RAMP for 256 with COUNTER sequencing 0..255;
  - READ=01 then READ=10, each with ROW_VALID high for one cycle;
  - FRAME_DONE pulses once, 5+255+256+4+1 = 521 cycles after ERASE first rises (counting the first ERASE cycle as cycle 1, FRAME_DONE is cycle 521).
- Backpressure: hold ROW_READY=0 for 7 cycles on row 0. ROW_VALID, READ=01 and ROW_INDEX=0 must hold unchanged; row 1 setup starts the cycle after ROW_READY rises.
- START pulses during EXPOSE_S are ignored: exactly one frame is produced and one FRAME_DONE pulse.
- Reset asserted at COUNTER=100: the next cycle shows IDLE with all outputs 0, and a fresh START then runs a complete normal frame.
- H=1, E=1, X=1 with ROW_READY high: the phase sequence is 1 ERASE, 1 EXPOSE, 256 RAMP, 1 setup, 1 valid cycle, then FRAME_DONE.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and widths for the pixel array sequencer.
// Holds the frame state encoding plus counter and phase timer sizing.
package pixel_ctrl_pkg;

  localparam int COUNTER_WIDTH     = 8;
  localparam int PHASE_TIMER_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    ERASE_S,
    EXPOSE_S,
    CONVERT,
    READ_SETUP,
    READ_VALID
  } state_t;

  // Row index width, kept at least one bit for a single-row array.
  function automatic int row_width(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter timing the erase and expose phases; zero is combinational from the count.
// Load wins over enable; the count parks at zero rather than wrapping.
module phase_timer
  import pixel_ctrl_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic                         enable,
  input  logic [PHASE_TIMER_WIDTH-1:0] load_value,
  output logic                         zero
);

  logic [PHASE_TIMER_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pixel_array_controller.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion, then per-row readout.
// All outputs registered; a row stays selected with ROW_VALID high until ROW_READY accepts it.
module pixel_array_controller
  import pixel_ctrl_pkg::*;
#(
  parameter  int PIXEL_ARRAY_HEIGHT = 2,
  parameter  int ERASE_CYCLES       = 5,
  parameter  int EXPOSE_CYCLES      = 255,
  localparam int ROW_W              = row_width(PIXEL_ARRAY_HEIGHT)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          START,
  output logic                          ERASE,
  output logic                          EXPOSE,
  output logic                          RAMP,
  output logic [COUNTER_WIDTH-1:0]      COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0] READ,
  output logic                          ROW_VALID,
  output logic [ROW_W-1:0]              ROW_INDEX,
  input  logic                          ROW_READY,
  output logic                          BUSY,
  output logic                          FRAME_DONE
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [PHASE_TIMER_WIDTH-1:0] ERASE_LOAD  = PHASE_TIMER_WIDTH'(ERASE_CYCLES - 1);
  localparam logic [PHASE_TIMER_WIDTH-1:0] EXPOSE_LOAD = PHASE_TIMER_WIDTH'(EXPOSE_CYCLES - 1);

  state_t                          state, state_nxt;
  logic [COUNTER_WIDTH-1:0]        cnt_nxt;
  logic [ROW_W-1:0]                row_nxt;
  logic [PIXEL_ARRAY_HEIGHT-1:0]   read_nxt;
  logic                            done_nxt;
  logic                            tmr_load, tmr_en, tmr_zero;
  logic [PHASE_TIMER_WIDTH-1:0]    tmr_val;

  phase_timer u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .enable     (tmr_en),
    .load_value (tmr_val),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // COUNTER and ROW_INDEX double as the conversion and row registers.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    row_nxt   = ROW_INDEX;
    done_nxt  = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = ERASE_LOAD;
    read_nxt  = '0;
    case (state)
      IDLE: begin
        if (START) begin
          state_nxt = ERASE_S;
          tmr_load  = 1'b1;
        end
      end
      ERASE_S: begin
        if (tmr_zero) begin
          state_nxt = EXPOSE_S;
          tmr_load  = 1'b1;
          tmr_val   = EXPOSE_LOAD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      EXPOSE_S: begin
        if (tmr_zero) state_nxt = CONVERT;
        else          tmr_en    = 1'b1;
      end
      CONVERT: begin
        if (COUNTER == '1) begin
          state_nxt = READ_SETUP;
          row_nxt   = '0;
        end else begin
          cnt_nxt = COUNTER + 1'b1;
        end
      end
      READ_SETUP: state_nxt = READ_VALID;
      READ_VALID: begin
        if (ROW_READY) begin
          if (ROW_INDEX == LAST_ROW) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = READ_SETUP;
            row_nxt   = ROW_INDEX + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if ((state_nxt == READ_SETUP) || (state_nxt == READ_VALID)) read_nxt[row_nxt] = 1'b1;
    else                                                         row_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      RAMP       <= 1'b0;
      COUNTER    <= '0;
      READ       <= '0;
      ROW_VALID  <= 1'b0;
      ROW_INDEX  <= '0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      ERASE      <= (state_nxt == ERASE_S);
      EXPOSE     <= (state_nxt == EXPOSE_S);
      RAMP       <= (state_nxt == CONVERT);
      COUNTER    <= cnt_nxt;
      READ       <= read_nxt;
      ROW_VALID  <= (state_nxt == READ_VALID);
      ROW_INDEX  <= row_nxt;
      BUSY       <= (state_nxt != IDLE);
      FRAME_DONE <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pixel_array_controller.sv
// Directed bench for pixel_array_controller: default array plus a 1-row, 1-cycle-phase array.
module tb_pixel_array_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start0, start1, ready, sel;

  logic       e0, x0, r0, v0, b0, fd0;
  logic [7:0] c0;
  logic [1:0] rd0;
  logic [0:0] ri0;
  logic       e1, x1, r1, v1, b1, fd1;
  logic [7:0] c1;
  logic [0:0] rd1;
  logic [0:0] ri1;

  pixel_array_controller dut0 (
    .clk(clk), .reset(reset), .START(start0), .ERASE(e0), .EXPOSE(x0), .RAMP(r0),
    .COUNTER(c0), .READ(rd0), .ROW_VALID(v0), .ROW_INDEX(ri0), .ROW_READY(ready),
    .BUSY(b0), .FRAME_DONE(fd0)
  );

  pixel_array_controller #(.PIXEL_ARRAY_HEIGHT(1), .ERASE_CYCLES(1), .EXPOSE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .START(start1), .ERASE(e1), .EXPOSE(x1), .RAMP(r1),
    .COUNTER(c1), .READ(rd1), .ROW_VALID(v1), .ROW_INDEX(ri1), .ROW_READY(ready),
    .BUSY(b1), .FRAME_DONE(fd1)
  );

  logic       m_erase, m_expose, m_ramp, m_vld, m_idx, m_busy, m_done;
  logic [7:0] m_cnt;
  logic [1:0] m_read;
  assign m_erase  = sel ? e1  : e0;
  assign m_expose = sel ? x1  : x0;
  assign m_ramp   = sel ? r1  : r0;
  assign m_cnt    = sel ? c1  : c0;
  assign m_read   = sel ? {1'b0, rd1} : rd0;
  assign m_vld    = sel ? v1  : v0;
  assign m_idx    = sel ? ri1[0] : ri0[0];
  assign m_busy   = sel ? b1  : b0;
  assign m_done   = sel ? fd1 : fd0;

  logic [16:0] vec0;
  logic [14:0] vec1;
  assign vec0 = {e0, x0, r0, c0, rd0, v0, ri0, b0, fd0};
  assign vec1 = {e1, x1, r1, c1, rd1, v1, ri1, b1, fd1};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int f_erase, n_erase, f_expose, n_expose, f_ramp, n_ramp, cnt_bad;
  int f_set0, f_val0, n_val0, f_set1, n_val1, done_c, n_done;
  int excl_bad, busy_bad, stable_bad, idx_bad;

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start0 = v;
  endtask

  task automatic kick();
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1 set_start(1'b0);
  endtask

  // Cycle 1 is the first negedge after the START edge; bp stalls row 0, poke fires stray STARTs.
  task automatic frame_mon(input bit bp, input bit poke, input int tail);
    logic [1:0] prd;
    logic       pidx, pv, prdy;
    f_erase = 0; n_erase = 0; f_expose = 0; n_expose = 0; f_ramp = 0; n_ramp = 0; cnt_bad = 0;
    f_set0 = 0; f_val0 = 0; n_val0 = 0; f_set1 = 0; n_val1 = 0; done_c = 0; n_done = 0;
    excl_bad = 0; busy_bad = 0; stable_bad = 0; idx_bad = 0;
    pv = 1'b0; prdy = 1'b1; prd = '0; pidx = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      if (m_erase)  begin if (n_erase == 0)  f_erase = c;  n_erase++;  end
      if (m_expose) begin if (n_expose == 0) f_expose = c; n_expose++; end
      if (m_ramp) begin
        if (m_cnt != 8'(n_ramp)) cnt_bad++;
        if (n_ramp == 0) f_ramp = c;
        n_ramp++;
      end else if (m_cnt != 8'd0) cnt_bad++;
      if (m_read == 2'b01) begin
        if (!m_vld) begin if (f_set0 == 0) f_set0 = c; end
        else begin if (f_val0 == 0) f_val0 = c; n_val0++; end
        if (m_idx != 1'b0) idx_bad++;
      end else if (m_read == 2'b10) begin
        if (!m_vld) begin if (f_set1 == 0) f_set1 = c; end
        else n_val1++;
        if (m_idx != 1'b1) idx_bad++;
      end else if ((m_read != 2'b00) || m_vld || m_idx) idx_bad++;
      if ($countones({m_erase, m_expose, m_ramp, m_read}) > 1) excl_bad++;
      if (m_busy != (m_erase | m_expose | m_ramp | (|m_read))) busy_bad++;
      if (pv && !prdy && !(m_vld && (m_read == prd) && (m_idx == pidx))) stable_bad++;
      if (m_done) begin n_done++; if (done_c == 0) done_c = c; end
      pv = m_vld; prd = m_read; pidx = m_idx;
      ready = !(bp && (n_val0 < 8));
      prdy  = ready;
      set_start(poke && ((c == 10) || (c == 100) || (c == 200)));
      if ((done_c != 0) && (c >= done_c + tail)) break;
    end
    ready = 1'b1;
  endtask

  task automatic chk_frame(input string t, input int ne, input int nx, input int s0,
                           input int nv0, input int s1, input int dn);
    chk({t, "_erase_first"},  f_erase,  1);
    chk({t, "_erase_len"},    n_erase,  ne);
    chk({t, "_expose_first"}, f_expose, 1 + ne);
    chk({t, "_expose_len"},   n_expose, nx);
    chk({t, "_ramp_first"},   f_ramp,   1 + ne + nx);
    chk({t, "_ramp_len"},     n_ramp,   256);
    chk({t, "_counter_seq"},  cnt_bad,  0);
    chk({t, "_row0_setup"},   f_set0,   s0);
    chk({t, "_row0_valid"},   f_val0,   s0 + 1);
    chk({t, "_row0_vcycles"}, n_val0,   nv0);
    chk({t, "_row1_setup"},   f_set1,   s1);
    chk({t, "_row1_vcycles"}, n_val1,   (s1 != 0) ? 1 : 0);
    chk({t, "_done_cycle"},   done_c,   dn);
    chk({t, "_done_pulses"},  n_done,   1);
    chk({t, "_exclusive"},    excl_bad, 0);
    chk({t, "_busy"},         busy_bad, 0);
    chk({t, "_hold"},         stable_bad, 0);
    chk({t, "_row_index"},    idx_bad,  0);
  endtask

  initial begin
    bit found;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; ready = 1'b1; sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs0", 32'(vec0), 0);
    chk("reset_outs1", 32'(vec1), 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outs", 32'(vec0), 0);
    end

    kick();
    frame_mon(1'b0, 1'b0, 20);
    chk_frame("full", 5, 255, 517, 1, 519, 521);

    kick();
    frame_mon(1'b1, 1'b0, 20);
    chk_frame("bp", 5, 255, 517, 8, 526, 528);

    kick();
    frame_mon(1'b0, 1'b1, 20);
    chk_frame("poke", 5, 255, 517, 1, 519, 521);

    // Reset in the middle of conversion.
    kick();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (r0 && (c0 == 8'd100)) found = 1'b1;
    end
    chk("cnt100_seen", int'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_outs", 32'(vec0), 0);
    reset = 1'b0;
    kick();
    frame_mon(1'b0, 1'b0, 20);
    chk_frame("after_rst", 5, 255, 517, 1, 519, 521);

    // Reset on the final handshake edge must suppress FRAME_DONE.
    kick();
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (v0 && (rd0 == 2'b10)) found = 1'b1;
    end
    chk("last_row_seen", int'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("done_cancel", 32'(fd0), 0);
    chk("done_cancel_outs", 32'(vec0), 0);
    reset = 1'b0;

    sel = 1'b1;
    kick();
    frame_mon(1'b0, 1'b0, 20);
    chk_frame("h1", 1, 1, 259, 1, 0, 261);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
